// File: rtl/mem_arbiter.sv
// Two-client arbiter sharing one line-wide memory port between the I-cache and D-cache.
// Round-robin on ties; a D write-back is kept atomic with the D refill that follows it.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  i_wait_cnt,
  output logic [CNT_W-1:0]  d_wait_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_last_owner_d;
  logic             r_lock_d;
  logic [CNT_W-1:0] r_i_wait;
  logic [CNT_W-1:0] r_d_wait;
  logic             w_i_req;
  logic             w_d_req;

  assign w_i_req = i_mem_read | i_mem_write;
  assign w_d_req = d_mem_read | d_mem_write;

  // A pending D refill after its own write-back beats every other rule, then round-robin.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (r_lock_d && w_d_req) begin
          w_next_state = OWN_D;
        end else if (w_i_req && w_d_req) begin
          w_next_state = r_last_owner_d ? OWN_I : OWN_D;
        end else if (w_i_req) begin
          w_next_state = OWN_I;
        end else if (w_d_req) begin
          w_next_state = OWN_D;
        end
      end
      OWN_I: if (mem_ready) w_next_state = IDLE;
      OWN_D: if (mem_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_mem_ready = 1'b0;
    d_mem_ready = 1'b0;
    case (r_state)
      OWN_I: begin
        mem_read    = i_mem_read;
        mem_write   = i_mem_write;
        mem_addr    = i_mem_addr;
        mem_wdata   = i_mem_wdata;
        i_mem_ready = mem_ready;
      end
      OWN_D: begin
        mem_read    = d_mem_read;
        mem_write   = d_mem_write;
        mem_addr    = d_mem_addr;
        mem_wdata   = d_mem_wdata;
        d_mem_ready = mem_ready;
      end
      default: ;
    endcase
  end

  // The lock only ever survives a single IDLE cycle, so it cannot starve the I-cache.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_last_owner_d <= 1'b1;
      r_lock_d       <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == OWN_I && mem_ready) begin
        r_last_owner_d <= 1'b0;
      end else if (r_state == OWN_D && mem_ready) begin
        r_last_owner_d <= 1'b1;
      end
      if (r_state == OWN_D && mem_ready && d_mem_write) begin
        r_lock_d <= 1'b1;
      end else if (r_state == IDLE) begin
        r_lock_d <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i_wait <= '0;
      r_d_wait <= '0;
    end else begin
      if (w_i_req && r_state != OWN_I && r_i_wait != '1) begin
        r_i_wait <= r_i_wait + CNT_W'(1);
      end
      if (w_d_req && r_state != OWN_D && r_d_wait != '1) begin
        r_d_wait <= r_d_wait + CNT_W'(1);
      end
    end
  end

  assign i_wait_cnt = r_i_wait;
  assign d_wait_cnt = r_d_wait;

endmodule
